// File: rtl/nfc_buf_pkg.sv
//==============================================================================
// nfc_buf_pkg -- shared state encoding and width defaults for the buffer ctrl
// rev 1.0
//==============================================================================
`default_nettype none

package nfc_buf_pkg;

   localparam int DEF_ADDR_A_WIDTH = 14;
   localparam int DEF_ADDR_B_WIDTH = 13;
   localparam int HW_WIDTH         = 16;
   localparam int WORD_WIDTH       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/buf_skid_fifo.sv
//==============================================================================
// buf_skid_fifo -- 2-entry output FIFO holding {last, word} read results
// rev 1.0
//==============================================================================
`default_nettype none

module buf_skid_fifo
   import nfc_buf_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_idx;
   logic             rd_idx;

   // The caller guarantees push never hits a full FIFO and pop never an empty one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_idx] <= push_data;
            wr_idx      <= ~wr_idx;
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_valid = (count != 2'd0);
   assign head_data  = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/sdpram_buf_ctrl.sv
//==============================================================================
// sdpram_buf_ctrl -- packs a halfword stream into 32-bit words via external SDP RAM
// rev 1.0
//==============================================================================
`default_nettype none

module sdpram_buf_ctrl
   import nfc_buf_pkg::*;
#(
   parameter int ADDR_A_WIDTH = DEF_ADDR_A_WIDTH,
   parameter int ADDR_B_WIDTH = DEF_ADDR_B_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_B_WIDTH:0]   xfer_words,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [HW_WIDTH-1:0]     in_data,
   output logic                    ram_ena,
   output logic [ADDR_A_WIDTH-1:0] ram_addra,
   output logic [HW_WIDTH-1:0]     ram_dina,
   output logic                    ram_enb,
   output logic [ADDR_B_WIDTH-1:0] ram_addrb,
   input  logic [WORD_WIDTH-1:0]   ram_doutb,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_WIDTH-1:0]   out_data,
   output logic                    out_last
);

   localparam int LVL_W = ADDR_A_WIDTH + 1;
   localparam int CNT_W = ADDR_B_WIDTH + 1;
   localparam logic [LVL_W-1:0] LEVEL_MAX = {1'b1, {ADDR_A_WIDTH{1'b0}}};

   buf_state_t              state;
   logic [CNT_W-1:0]        len;
   logic [CNT_W-1:0]        issued;
   logic [LVL_W-1:0]        hw_cnt;
   logic [LVL_W-1:0]        level;
   logic [LVL_W-1:0]        hw_target;
   logic [ADDR_A_WIDTH-1:0] wr_ptr;
   logic [ADDR_B_WIDTH-1:0] rd_ptr;
   logic                    inflight;
   logic                    inflight_last;
   logic                    done_r;

   logic                    accept;
   logic                    rd_issue;
   logic                    pop;
   logic                    pop_last;
   logic                    fifo_valid;
   logic [WORD_WIDTH:0]     fifo_head;
   logic [1:0]              fifo_cnt;

   assign hw_target = {len, 1'b0};
   assign in_ready  = (state == ST_RUN) && (level < LEVEL_MAX) && (hw_cnt < hw_target);
   assign accept    = in_valid && in_ready;

   // Reads in flight count against FIFO space so the capture never overflows.
   assign rd_issue  = (state != ST_IDLE) && (level >= LVL_W'(2)) && (issued < len) &&
                      (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2);

   assign pop       = fifo_valid && out_ready;
   assign pop_last  = pop && fifo_head[WORD_WIDTH];

   assign ram_ena   = accept;
   assign ram_addra = wr_ptr;
   assign ram_dina  = accept ? in_data : '0;
   assign ram_enb   = rd_issue;
   assign ram_addrb = rd_ptr;
   assign out_valid = fifo_valid;
   assign out_data  = fifo_head[WORD_WIDTH-1:0];
   assign out_last  = fifo_valid && fifo_head[WORD_WIDTH];
   assign busy      = (state != ST_IDLE);
   assign done      = done_r;

   buf_skid_fifo #(
      .WIDTH (WORD_WIDTH + 1)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (abort),
      .push       (inflight),
      .push_data  ({inflight_last, ram_doutb}),
      .pop        (pop),
      .head_valid (fifo_valid),
      .head_data  (fifo_head),
      .count      (fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         len           <= '0;
         issued        <= '0;
         hw_cnt        <= '0;
         level         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done_r        <= 1'b0;
      end else if (abort) begin
         state         <= ST_IDLE;
         issued        <= '0;
         hw_cnt        <= '0;
         level         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         done_r        <= 1'b0;
         inflight      <= rd_issue;
         inflight_last <= rd_issue && (issued == len - CNT_W'(1));
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            hw_cnt <= hw_cnt + 1'b1;
         end
         if (rd_issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            issued <= issued + 1'b1;
         end
         level <= level + LVL_W'(accept) - (rd_issue ? LVL_W'(2) : LVL_W'(0));

         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (xfer_words == '0) begin
                     done_r <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                     len    <= xfer_words;
                     issued <= '0;
                     hw_cnt <= '0;
                     level  <= '0;
                     wr_ptr <= '0;
                     rd_ptr <= '0;
                  end
               end
            end
            ST_RUN: begin
               if (accept && (hw_cnt + 1'b1 == hw_target)) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop_last) begin
                  state  <= ST_IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sdpram_buf_ctrl.sv
//==============================================================================
// tb_sdpram_buf_ctrl -- scoreboard bench for sdpram_buf_ctrl with a RAM model
// rev 1.0
//==============================================================================
`default_nettype none

module tb_sdpram_buf_ctrl;

   localparam int AW = 14;
   localparam int BW = 13;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [BW:0]   xfer_words;
   logic          abort;
   logic          busy;
   logic          done;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic          ram_ena;
   logic [AW-1:0] ram_addra;
   logic [15:0]   ram_dina;
   logic          ram_enb;
   logic [BW-1:0] ram_addrb;
   logic [31:0]   ram_doutb;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic          out_last;

   sdpram_buf_ctrl #(
      .ADDR_A_WIDTH (AW),
      .ADDR_B_WIDTH (BW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .xfer_words (xfer_words),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .ram_ena    (ram_ena),
      .ram_addra  (ram_addra),
      .ram_dina   (ram_dina),
      .ram_enb    (ram_enb),
      .ram_addrb  (ram_addrb),
      .ram_doutb  (ram_doutb),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External RAM model: 16-bit write port, 32-bit registered read port.
   logic [15:0] ram [0:(1<<AW)-1];
   logic [31:0] doutb_r;
   assign ram_doutb = doutb_r;
   always @(posedge clk) begin
      if (ram_ena) ram[ram_addra] <= ram_dina;
      if (ram_enb) doutb_r <= {ram[{ram_addrb, 1'b1}], ram[{ram_addrb, 1'b0}]};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   logic [32:0] exp_q[$];
   int last_pop_cyc = -1;
   int wr_exp = 0;
   int rd_exp = 0;
   int enb_cnt = 0;
   int act_cnt = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            check("pop_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_word", {31'b0, out_last, out_data}, {31'b0, e});
            end
            if (out_last) last_pop_cyc = cyc;
         end
         if (ram_ena) begin
            check("wr_addr", 64'(ram_addra), 64'(wr_exp));
            wr_exp++;
         end
         if (ram_enb) begin
            check("rd_addr", 64'(ram_addrb), 64'(rd_exp));
            rd_exp++;
            enb_cnt++;
         end
         if (ram_ena || ram_enb || out_valid) act_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int words);
      start      = 1'b1;
      xfer_words = (BW+1)'(words);
      wr_exp     = 0;
      rd_exp     = 0;
      step();
      start      = 1'b0;
   endtask

   // Hand-computed words: halfword i carries base+i, word k = {base+2k+1, base+2k}.
   task automatic push_words(input int n, input int base);
      logic [15:0] lo;
      logic [15:0] hi;
      for (int k = 0; k < n; k++) begin
         lo = 16'(base + 2*k);
         hi = 16'(base + 2*k + 1);
         exp_q.push_back({(k == n-1), hi, lo});
      end
   endtask

   task automatic send(input int n, input int base, output int stalls);
      int  i     = 0;
      int  guard = 0;
      logic acc;
      stalls   = 0;
      in_valid = 1'b1;
      in_data  = 16'(base);
      while (i < n && guard < 40000) begin
         @(negedge clk);
         acc = in_ready;
         if (!in_ready) stalls++;
         step();
         if (acc) begin
            i++;
            in_data = 16'(base + i);
         end
         guard++;
      end
      in_valid = 1'b0;
      check("send_complete", 64'(i), 64'(n));
   endtask

   task automatic wait_done(input int bound, output int dcyc);
      int k = 0;
      dcyc = -1;
      while (k < bound) begin
         @(negedge clk);
         if (done) begin
            dcyc = cyc;
            break;
         end
         k++;
      end
      check("done_seen", 64'(done), 1);
      check("idle_with_done", 64'(busy), 0);
      step();
   endtask

   initial begin
      int st;
      int dc;
      int t0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      in_data = '0; xfer_words = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {58'b0, busy, done, in_ready, out_valid, ram_ena, ram_enb}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      step();

      // Basic 4-word transfer, consumer always ready.
      out_ready = 1'b1;
      push_words(4, 1);
      do_start(4);
      @(negedge clk);
      check("t025_busy", 64'(busy), 1);
      step();
      send(8, 1, st);
      wait_done(100, dc);
      check("t025_done_after_last", 64'(dc), 64'(last_pop_cyc + 1));
      check("t025_queue_empty", 64'(exp_q.size()), 0);

      // Back-pressure: only two words may be read ahead while out_ready is low.
      out_ready = 1'b0;
      push_words(3, 'h100);
      t0 = cyc;
      enb_cnt = 0;
      do_start(3);
      send(6, 'h100, st);
      check("t026_no_stall", 64'(st), 0);
      while (cyc < t0 + 20) step();
      check("t026_reads_held", 64'(enb_cnt), 2);
      out_ready = 1'b1;
      wait_done(100, dc);
      check("t026_reads_total", 64'(enb_cnt), 3);
      check("t026_queue_empty", 64'(exp_q.size()), 0);

      // Full RAM fill, then drain.
      out_ready = 1'b0;
      push_words(8192, 0);
      do_start(8192);
      send(16384, 0, st);
      check("t027_no_stall", 64'(st), 0);
      out_ready = 1'b1;
      wait_done(40000, dc);
      check("t027_queue_empty", 64'(exp_q.size()), 0);

      // Zero-length transfer.
      out_ready = 1'b0;
      act_cnt = 0;
      done_cnt = 0;
      start = 1'b1;
      xfer_words = '0;
      @(negedge clk);
      check("t028_no_early_done", 64'(done), 0);
      step();
      start = 1'b0;
      @(negedge clk);
      check("t028_done", 64'(done), 1);
      check("t028_not_busy", 64'(busy), 0);
      step();
      repeat (3) step();
      check("t028_done_count", 64'(done_cnt), 1);
      check("t028_no_activity", 64'(act_cnt), 0);

      // Abort mid-transfer, abort beats start, then a clean restart.
      done_cnt = 0;
      do_start(8);
      send(5, 'h200, st);
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clk);
      check("t029_busy_cleared", 64'(busy), 0);
      check("t029_out_valid_cleared", 64'(out_valid), 0);
      step();
      repeat (4) step();
      check("t029_no_done", 64'(done_cnt), 0);
      start = 1'b1;
      abort = 1'b1;
      xfer_words = (BW+1)'(2);
      step();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("t029_abort_beats_start", 64'(busy), 0);
      step();
      out_ready = 1'b1;
      push_words(2, 'h300);
      do_start(2);
      send(4, 'h300, st);
      wait_done(100, dc);
      check("t029_queue_empty", 64'(exp_q.size()), 0);

      // Asynchronous reset while words sit in the FIFO.
      out_ready = 1'b0;
      push_words(2, 'h400);
      do_start(2);
      send(4, 'h400, st);
      repeat (3) step();
      check("t030_in_drain", {62'b0, busy, out_valid}, 3);
      #2 rst_n = 1'b0;
      #1;
      check("t030_async_reset",
            {24'b0, busy, done, in_ready, out_valid, ram_ena, ram_enb, out_last, out_data}, 0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("t030_idle_after_release", 64'(busy), 0);
      step();
      out_ready = 1'b1;
      push_words(1, 'h500);
      do_start(1);
      send(2, 'h500, st);
      wait_done(100, dc);
      check("t030_queue_empty", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion (%0d/%0d so far)", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
